instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 mem_conflict  input  1  the data stage owns the shared memory this cycle, so the fetch word is invalid.
REQ-004 stall  input  1  load-use hold from the hazard unit; freezes PC and IF/ID.
REQ-005 branch_taken  input  1  redirect request from the ID stage.
REQ-006 branch_target  input  16  redirect byte address, used unmodified.
REQ-007 instr_in  input  16  instruction memory data, combinational on fetch_pc.
REQ-008 fetch_pc  output  16  byte address driven to instruction memory; word index is fetch_pc>>2.
REQ-009 id_instr  output  16  IF/ID instruction register.
REQ-010 id_pc  output  16  byte address of id_instr.
REQ-011 id_valid  output  1  1 when id_instr is a real fetched instruction, 0 when it is a bubble.
REQ-012 bubble_cnt  output  8  saturating count of bubbles inserted since reset.

Function
REQ-013 The block SHALL use the state set BOOT, RUN and HOLD, held in a registered state variable.
REQ-014 BOOT SHALL last exactly one cycle after rst deasserts: fetch_pc=0x0000, IF/ID loads bubble, then next state is RUN.
REQ-015 A bubble SHALL be defined as: id_instr=0x0800 (NOP), id_valid=0, and id_pc unchanged.
REQ-016 Each RUN/HOLD cycle SHALL apply exactly one action, in priority order: branch_taken > stall > mem_conflict > normal.
REQ-017 branch_taken=1: fetch_pc<=branch_target, IF/ID<=bubble (wrong-path squash), next state RUN; this applies regardless of stall or mem_conflict.
REQ-018 stall=1 (no branch): fetch_pc, id_instr, id_pc, id_valid and state SHALL all hold, with no bubble counted.
REQ-019 mem_conflict=1 (no branch, no stall): fetch_pc holds, IF/ID<=bubble, next state HOLD.
REQ-020 Normal: IF/ID<=instr_in, id_pc<=fetch_pc, id_valid<=1, fetch_pc<=fetch_pc+4, next state RUN.
REQ-021 From HOLD, the first cycle with mem_conflict=0 and no stall SHALL refetch the held fetch_pc, so no instruction is lost or duplicated.
REQ-022 fetch_pc+4 SHALL wrap modulo 2^16 (0xFFFC -> 0x0000).
REQ-023 bubble_cnt SHALL increment on every bubble load in BOOT, branch or conflict cycles, and SHALL saturate at 0xFF.
REQ-024 Latency SHALL be one cycle: instr_in sampled at edge N appears on id_instr after edge N.
REQ-025 fetch_pc SHALL be a register output, never combinational from inputs.

Reset
REQ-026 On rst=0, immediately and independent of clk: state=BOOT, fetch_pc=0x0000, id_instr=0x0800, id_pc=0x0000, id_valid=0, bubble_cnt=0.
REQ-027 rst asserted mid-stall, mid-HOLD or during a branch SHALL discard all pending actions; on release the block restarts from REQ-014.

Verification
REQ-028 Reset release, no hazards, memory word k=0x1000+k -> fetch_pc 0,0,4,8,...; id_instr 0x0800 then 0x1000,0x1001,...; id_valid 0 then 1; bubble_cnt=1.
REQ-029 mem_conflict high for 2 cycles at fetch_pc=0x0008 -> two bubbles with id_valid=0, fetch_pc held at 0x0008, then id_instr=word 2 with id_pc=0x0008; bubble_cnt +2.
REQ-030 branch_taken with target 0x0040, simultaneous stall=1 and mem_conflict=1 -> next fetch_pc=0x0040, IF/ID bubble, state RUN.
REQ-031 stall high for 3 cycles -> id_instr, id_pc, fetch_pc and bubble_cnt unchanged across all 3 cycles; normal flow resumes afterwards.
REQ-032 Branch to 0xFFFC, then normal flow -> id_pc=0xFFFC, next fetch_pc=0x0000.
REQ-033 Force 300 mem_conflict cycles, then assert rst while in HOLD -> bubble_cnt saturates at 0xFF; asynchronous clear to the REQ-026 values.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Bubble squash on branch/memory conflict, freeze on load-use stall.
module instr_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_conflict,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] instr_in,
    output logic [15:0] fetch_pc,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_valid,
    output logic [7:0]  bubble_cnt,
    output logic [1:0]  dbg_state
);

    localparam logic [15:0] NOP = 16'h0800;

    // Encoding is visible on dbg_state: BOOT=0, RUN=1, HOLD=2.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] instr_nxt;
    logic [15:0] idpc_nxt;
    logic        valid_nxt;
    logic        bubble;

    // id_valid qualifies id_instr for the ID stage: 1 = real instruction,
    // 0 = bubble. There is no back-pressure path other than stall.
    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        instr_nxt = id_instr;
        idpc_nxt  = id_pc;
        valid_nxt = id_valid;
        bubble    = 1'b0;

        case (state)
            BOOT: begin
                pc_nxt    = 16'h0000;
                bubble    = 1'b1;
                state_nxt = RUN;
            end
            RUN, HOLD: begin
                if (branch_taken) begin
                    // Wrong-path squash wins over any hazard.
                    pc_nxt    = branch_target;
                    bubble    = 1'b1;
                    state_nxt = RUN;
                end else if (stall) begin
                    state_nxt = state;
                end else if (mem_conflict) begin
                    // PC holds so the lost word is refetched once memory frees up.
                    bubble    = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    instr_nxt = instr_in;
                    idpc_nxt  = fetch_pc;
                    valid_nxt = 1'b1;
                    pc_nxt    = fetch_pc + 16'd4;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase

        if (bubble) begin
            instr_nxt = NOP;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            fetch_pc   <= 16'h0000;
            id_instr   <= NOP;
            id_pc      <= 16'h0000;
            id_valid   <= 1'b0;
            bubble_cnt <= 8'h00;
        end else begin
            state    <= state_nxt;
            fetch_pc <= pc_nxt;
            id_instr <= instr_nxt;
            id_pc    <= idpc_nxt;
            id_valid <= valid_nxt;
            if (bubble && (bubble_cnt != 8'hFF))
                bubble_cnt <= bubble_cnt + 8'd1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, reset corner cases,
// then randomized hazards against a behavioural pipeline model.
module tb_instr_fetch;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_conflict = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] instr_in;
    logic [15:0] fetch_pc;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_valid;
    logic [7:0]  bubble_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .mem_conflict (mem_conflict),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr_in     (instr_in),
        .fetch_pc     (fetch_pc),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .bubble_cnt   (bubble_cnt),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k holds 0x1000 + k.
    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        return 16'h1000 + {2'b00, addr[15:2]};
    endfunction

    assign instr_in = mem_word(fetch_pc);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                           input logic [15:0] e_idpc, input logic e_v, input logic [7:0] e_cnt,
                           input logic [1:0] e_st);
        chk({tag, ".fetch_pc"}, fetch_pc, e_pc);
        chk({tag, ".id_instr"}, id_instr, e_instr);
        chk({tag, ".id_pc"}, id_pc, e_idpc);
        chk({tag, ".id_valid"}, {15'd0, id_valid}, {15'd0, e_v});
        chk({tag, ".bubble_cnt"}, {8'd0, bubble_cnt}, {8'd0, e_cnt});
        chk({tag, ".state"}, {14'd0, dbg_state}, {14'd0, e_st});
    endtask

    // Drive one cycle of inputs, clock it, settle just after the edge.
    task automatic apply(input logic b, input logic s, input logic m, input logic [15:0] t);
        branch_taken  = b;
        stall         = s;
        mem_conflict  = m;
        branch_target = t;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        br, st, mc;
        logic [15:0] tgt;
        logic [15:0] pc, instr, idpc;
        logic        v;
        logic [7:0]  cnt;
        logic [1:0]  state;
    } vec_t;

    vec_t tbl[18];

    // Behavioural reference: pipeline register contents after each clock.
    logic        m_boot;
    logic [1:0]  m_state;
    logic [15:0] m_pc, m_instr, m_idpc;
    logic        m_v;
    int          m_bubbles;

    task automatic model_reset();
        m_boot = 1'b1; m_state = S_BOOT; m_pc = 16'h0000;
        m_instr = 16'h0800; m_idpc = 16'h0000; m_v = 1'b0; m_bubbles = 0;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0800;
        m_v = 1'b0;
        m_bubbles++;
    endtask

    task automatic model_step(input logic b, input logic s, input logic m, input logic [15:0] t);
        if (m_boot) begin
            m_boot = 1'b0; m_pc = 16'h0000; model_bubble(); m_state = S_RUN;
        end else if (b) begin
            m_pc = t; model_bubble(); m_state = S_RUN;
        end else if (s) begin
            // everything frozen
        end else if (m) begin
            model_bubble(); m_state = S_HOLD;
        end else begin
            m_instr = mem_word(m_pc); m_idpc = m_pc; m_v = 1'b1;
            m_pc = 16'((32'(m_pc) + 4) % 65536);
            m_state = S_RUN;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 8'd1, S_RUN};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h1000, 16'h0000, 1'b1, 8'd1, S_RUN};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 16'h1001, 16'h0004, 1'b1, 8'd1, S_RUN};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0008, 16'h0800, 16'h0004, 1'b0, 8'd2, S_HOLD};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0008, 16'h0800, 16'h0004, 1'b0, 8'd3, S_HOLD};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h000C, 16'h1002, 16'h0008, 1'b1, 8'd3, S_RUN};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h000C, 16'h1002, 16'h0008, 1'b1, 8'd3, S_RUN};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h000C, 16'h1002, 16'h0008, 1'b1, 8'd3, S_RUN};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h000C, 16'h1002, 16'h0008, 1'b1, 8'd3, S_RUN};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h1003, 16'h000C, 1'b1, 8'd3, S_RUN};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h0040, 16'h0040, 16'h0800, 16'h000C, 1'b0, 8'd4, S_RUN};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0044, 16'h1010, 16'h0040, 1'b1, 8'd4, S_RUN};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'hFFFC, 16'hFFFC, 16'h0800, 16'h0040, 1'b0, 8'd5, S_RUN};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4FFF, 16'hFFFC, 1'b1, 8'd5, S_RUN};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h1000, 16'h0000, 1'b1, 8'd5, S_RUN};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0004, 16'h0800, 16'h0000, 1'b0, 8'd6, S_HOLD};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0800, 16'h0000, 1'b0, 8'd6, S_HOLD};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 16'h1001, 16'h0004, 1'b1, 8'd6, S_RUN};

        // Asynchronous reset before any clock edge
        #3 rst = 1'b0;
        #1 chk_all("reset", 16'h0000, 16'h0800, 16'h0000, 1'b0, 8'd0, S_BOOT);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].br, tbl[i].st, tbl[i].mc, tbl[i].tgt);
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].instr, tbl[i].idpc,
                    tbl[i].v, tbl[i].cnt, tbl[i].state);
        end

        // Long conflict run saturates the bubble counter
        for (int i = 0; i < 300; i++) apply(1'b0, 1'b0, 1'b1, 16'h0000);
        chk_all("sat", 16'h0008, 16'h0800, 16'h0004, 1'b0, 8'hFF, S_HOLD);

        // Reset in HOLD clears without a clock edge
        #2 rst = 1'b0;
        #1 chk_all("rst_hold", 16'h0000, 16'h0800, 16'h0000, 1'b0, 8'd0, S_BOOT);
        @(posedge clk); #1;
        rst = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 16'h0000);
        apply(1'b0, 1'b0, 1'b0, 16'h0000);
        chk_all("pre_br", 16'h0004, 16'h1000, 16'h0000, 1'b1, 8'd1, S_RUN);

        // Reset during a pending branch+stall discards the branch
        branch_taken = 1'b1; branch_target = 16'h0080; stall = 1'b1;
        #2 rst = 1'b0;
        #1 chk_all("rst_br", 16'h0000, 16'h0800, 16'h0000, 1'b0, 8'd0, S_BOOT);
        @(posedge clk); #1;
        rst = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 16'h0080);
        chk_all("boot_again", 16'h0000, 16'h0800, 16'h0000, 1'b0, 8'd1, S_RUN);

        // Randomized hazards against the reference model
        rst = 1'b0;
        #1 model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 500; i++) begin
            logic b, s, m;
            logic [15:0] t;
            b = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 4) == 0);
            m = ($urandom_range(0, 3) == 0);
            t = 16'($urandom_range(0, 65535));
            model_step(b, s, m, t);
            apply(b, s, m, t);
            chk_all($sformatf("rnd%0d", i), m_pc, m_instr, m_idpc, m_v,
                    (m_bubbles > 255) ? 8'hFF : 8'(m_bubbles), m_state);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
